mips_mc_control: RTL and testbench

Multi-cycle control FSM for the MIPS CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. Per cycle it drives the next-PC generator select (`PC_Src`), the PC and IR write enables, and the memory, register-file and ALU-mux controls. It sits beside the datapath, decodes the latched instruction fields, stalls on a memory-ready handshake, and counts retired instructions.

---
 rtl/mips_mc_control.sv | 172 +++++++++++++++++
 tb/tb_mips_mc_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch/decode/execute/memory/write-back,
// stalls on the memory-ready handshake and counts retired instructions.
//
// state      | meaning
// FETCH      | read instruction at PC; load IR and PC+4 when memory is ready
// DECODE     | classify opcode/funct, latch per-instruction flags
// EXEC_R     | R-type ALU operation on rs, rt
// EXEC_I     | addi: rs + sext_Immed
// MEM_ADDR   | lw/sw effective address rs + sext_Immed
// MEM_RD     | data read at alu_out_reg, wait for memory
// MEM_WB     | write MDR to rt
// MEM_WR     | data write at alu_out_reg, wait for memory
// R_WB       | write alu_out_reg to rd (or rt for addi)
// BRANCH     | compare rs - rt, conditionally load branch target
// JUMP       | load jump target
// JR         | load rs into PC
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [1:0]       PC_Src,
  output logic             PC_Write,
  output logic             IR_Write,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_JR
  } state_t;

  state_t           state_q;
  logic             is_imm_q;
  logic             is_sw_q;
  logic             is_bne_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire_en;

  assign retire_en = (state_q inside {S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR})
                   || ((state_q == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      is_imm_q  <= 1'b0;
      is_sw_q   <= 1'b0;
      is_bne_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (retire_en) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          // Flags hold the decode result so later states do not depend on IR staying put.
          is_imm_q <= (opcode == OP_ADDI);
          is_sw_q  <= (opcode == OP_SW);
          is_bne_q <= (opcode == OP_BNE);
          case (opcode)
            OP_RTYPE:     state_q <= (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_ADDI:      state_q <= S_EXEC_I;
            OP_BEQ, OP_BNE: state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_R_WB;
        S_MEM_ADDR: state_q <= is_sw_q ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PC_Src   = 2'b00;
    PC_Write = 1'b0;
    IR_Write = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IR_Write = mem_ready;
        PC_Write = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = ~is_imm_q;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PC_Src   = 2'b01;
        PC_Write = is_bne_q ? ~alu_zero : alu_zero;
      end
      S_JUMP: begin
        PC_Src   = 2'b10;
        PC_Write = 1'b1;
      end
      S_JR: begin
        ALUSrcA  = 1'b1;
        PC_Src   = 2'b11;
        PC_Write = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: each instruction is expanded into its expected per-cycle control pattern
// (with memory wait cycles) and replayed against the DUT, tracking the retired count alongside.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  PC_Src, ALUSrcB, ALUOp;
  logic        PC_Write, IR_Write, IorD, MemRead, MemWrite, RegWrite;
  logic        RegDst, MemtoReg, ALUSrcA, illegal;
  logic [31:0] retired;

  mips_mc_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .PC_Src(PC_Src), .PC_Write(PC_Write), .IR_Write(IR_Write), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] outs;
  assign outs = {PC_Src, PC_Write, IR_Write, IorD, MemRead, MemWrite, RegWrite,
                 RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal};

  typedef struct packed {
    logic [15:0] exp;
    logic [15:0] care;
    logic        mr;
    logic        az;
    logic        ret;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
  } cyc_t;

  string names [12] = '{"FETCH", "DECODE", "EXEC_R", "EXEC_I", "MEM_ADDR", "MEM_RD",
                        "MEM_WB", "MEM_WR", "R_WB", "BRANCH", "JUMP", "JR"};

  int          n_chk = 0;
  int          n_err = 0;
  cyc_t        q[$];
  logic [31:0] exp_ret;
  logic        ill_pend;
  logic [5:0]  cur_op, cur_fn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [1:0] pcs, input logic pw, input logic irw,
                                     input logic iord, input logic mrd, input logic mwr,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic ill);
    return {pcs, pw, irw, iord, mrd, mwr, rw, rd, m2r, asa, asb, aop, ill};
  endfunction

  // Enables and the illegal flag are always checked; other fields only where the state defines them.
  task automatic push(input int st, input logic [15:0] e, input logic [15:0] c,
                      input logic mr, input logic az, input logic ret);
    cyc_t r;
    r.exp  = e;
    r.care = c | pk(2'd0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 1);
    r.mr   = mr;
    r.az   = az;
    r.ret  = ret;
    r.op   = cur_op;
    r.fn   = cur_fn;
    r.st   = 4'(st);
    q.push_back(r);
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  // kind: 0 R, 1 addi, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jr, 8 illegal (opcode iop)
  task automatic gen(input int kind, input int fw, input int mw, input logic az,
                     input logic [5:0] iop);
    logic [15:0] alu_c, pcs_c;
    logic        pw;
    alu_c = pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 2'd3, 0);
    pcs_c = pk(2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    cur_fn = 6'($urandom_range(0, 63));
    case (kind)
      0: begin cur_op = 6'h00; while (cur_fn == 6'h08) cur_fn = 6'($urandom_range(0, 63)); end
      1: cur_op = 6'h08;
      2: cur_op = 6'h23;
      3: cur_op = 6'h2b;
      4: cur_op = 6'h04;
      5: cur_op = 6'h05;
      6: cur_op = 6'h02;
      7: begin cur_op = 6'h00; cur_fn = 6'h08; end
      default: cur_op = iop;
    endcase
    for (int i = 0; i <= fw; i++) begin
      push(0, pk(2'd0, (i == fw), (i == fw), 0, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, ill_pend),
           pcs_c | alu_c | pk(2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0),
           (i == fw), 1'($urandom), 0);
      ill_pend = 1'b0;
    end
    push(1, '0, '0, 1'($urandom), 1'($urandom), 0);
    case (kind)
      0, 1: begin
        if (kind == 0) push(2, pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0), alu_c,
                            1'($urandom), 1'($urandom), 0);
        else           push(3, pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0), alu_c,
                            1'($urandom), 1'($urandom), 0);
        push(8, pk(2'd0, 0, 0, 0, 0, 0, 1, (kind == 0), 0, 0, 2'd0, 2'd0, 0),
             pk(2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0), 1'($urandom), 1'($urandom), 1);
      end
      2, 3: begin
        push(4, pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0), alu_c,
             1'($urandom), 1'($urandom), 0);
        for (int i = 0; i <= mw; i++) begin
          if (kind == 2)
            push(5, pk(2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0),
                 pk(2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), (i == mw), 1'($urandom), 0);
          else
            push(7, pk(2'd0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0),
                 pk(2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), (i == mw), 1'($urandom),
                 (i == mw));
        end
        if (kind == 2)
          push(6, pk(2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0),
               pk(2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0), 1'($urandom), 1'($urandom), 1);
      end
      4, 5: begin
        pw = (kind == 4) ? az : ~az;
        push(9, pk(2'd1, pw, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0), alu_c | pcs_c,
             1'($urandom), az, 1);
      end
      6: push(10, pk(2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), pcs_c,
              1'($urandom), 1'($urandom), 1);
      7: push(11, pk(2'd3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0), alu_c | pcs_c,
              1'($urandom), 1'($urandom), 1);
      default: ill_pend = 1'b1;
    endcase
  endtask

  task automatic run(input int n);
    cyc_t r;
    int   cnt;
    cnt = 0;
    while (q.size() > 0 && (n < 0 || cnt < n)) begin
      r = q.pop_front();
      @(negedge clk);
      opcode    = r.op;
      funct     = r.fn;
      mem_ready = r.mr;
      alu_zero  = r.az;
      #1;
      check(names[int'(r.st)], {16'd0, outs & r.care}, {16'd0, r.exp & r.care});
      check({"retired@", names[int'(r.st)]}, retired, exp_ret);
      if (r.ret) exp_ret = exp_ret + 32'd1;
      cnt++;
    end
  endtask

  initial begin
    logic [5:0] iop;
    exp_ret  = '0;
    ill_pend = 1'b0;
    cur_op   = '0;
    cur_fn   = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_retired", retired, 32'd0);
    check("rst_fetch", {29'd0, MemRead, IorD, illegal}, {29'd0, 3'b100});
    rst_n = 1'b1;

    gen(2, 0, 0, 0, '0);
    gen(4, 0, 0, 1, '0);
    gen(4, 0, 0, 0, '0);
    gen(6, 0, 0, 0, '0);
    gen(7, 0, 0, 0, '0);
    gen(3, 0, 3, 0, '0);
    gen(8, 0, 0, 0, 6'h3f);
    gen(0, 1, 0, 0, '0);
    gen(1, 0, 0, 0, '0);
    gen(5, 0, 0, 1, '0);
    gen(5, 0, 0, 0, '0);
    gen(2, 2, 2, 0, '0);
    run(-1);

    // Reset while a load is waiting in MEM_RD, with memory claiming ready.
    gen(2, 0, 3, 0, '0);
    run(4);
    q.delete();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_in_memrd", {30'd0, MemRead, IorD}, {30'd0, 2'b11});
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("post_rst_fetch", {29'd0, MemRead, IorD, IR_Write}, {29'd0, 3'b100});
    check("post_rst_retired", retired, 32'd0);
    exp_ret  = '0;
    ill_pend = 1'b0;

    for (int k = 0; k < 300; k++) begin
      iop = 6'($urandom_range(0, 63));
      while (is_legal(iop)) iop = 6'($urandom_range(0, 63));
      gen($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), iop);
      run(-1);
    end
    gen(6, 0, 0, 0, '0);
    run(-1);
    @(negedge clk);
    #1;
    check("final_retired", retired, exp_ret);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
